// File: rtl/one_two_demux32.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | one_two_demux32 : 1-to-2 word demux with a 2-entry FIFO per port    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+

module one_two_demux32_fifo2 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       level
);
    logic [WIDTH-1:0] r_head;
    logic [WIDTH-1:0] r_tail;
    logic [1:0]       r_level;

    // Shift-style FIFO: the oldest word always sits in r_head, so the port
    // data output is a plain register with no read mux.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_level <= 2'd0;
        end else if (pop && push) begin
            if (r_level == 2'd2) begin
                r_head <= r_tail;
                r_tail <= din;
            end else begin
                r_head <= din;
            end
        end else if (pop) begin
            r_head  <= r_tail;
            r_tail  <= '0;
            r_level <= r_level - 2'd1;
        end else if (push) begin
            if (r_level == 2'd0) begin
                r_head <= din;
            end else begin
                r_tail <= din;
            end
            r_level <= r_level + 2'd1;
        end
    end

    assign head  = r_head;
    assign level = r_level;
endmodule

module one_two_demux32 #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] a_data,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] b_data,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [1:0]       a_level,
    output logic [1:0]       b_level,
    output logic [CNT_W-1:0] a_count,
    output logic [CNT_W-1:0] b_count,
    input  logic             cnt_clr
);
    localparam logic [1:0] C_FULL = 2'd2;

    logic             w_push_a;
    logic             w_push_b;
    logic             w_pop_a;
    logic             w_pop_b;
    logic [CNT_W-1:0] r_a_count;
    logic [CNT_W-1:0] r_b_count;

    // Readiness looks only at current occupancy, never at a same-cycle pop.
    assign in_ready = rst_n & (in_sel ? (b_level != C_FULL) : (a_level != C_FULL));

    assign w_push_a = in_valid & in_ready & ~in_sel;
    assign w_push_b = in_valid & in_ready & in_sel;
    assign a_valid  = (a_level != 2'd0);
    assign b_valid  = (b_level != 2'd0);
    assign w_pop_a  = a_valid & a_ready;
    assign w_pop_b  = b_valid & b_ready;

    one_two_demux32_fifo2 #(.WIDTH(WIDTH)) u_fifo_a (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push_a),
        .pop   (w_pop_a),
        .din   (in_data),
        .head  (a_data),
        .level (a_level)
    );

    one_two_demux32_fifo2 #(.WIDTH(WIDTH)) u_fifo_b (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push_b),
        .pop   (w_pop_b),
        .din   (in_data),
        .head  (b_data),
        .level (b_level)
    );

    // Clear wins over a coincident delivery.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_count <= '0;
            r_b_count <= '0;
        end else if (cnt_clr) begin
            r_a_count <= '0;
            r_b_count <= '0;
        end else begin
            if (w_pop_a) begin
                r_a_count <= r_a_count + CNT_W'(1);
            end
            if (w_pop_b) begin
                r_b_count <= r_b_count + CNT_W'(1);
            end
        end
    end

    assign a_count = r_a_count;
    assign b_count = r_b_count;
endmodule
`default_nettype wire
